// File: rtl/add_seq_if.sv
// Handshake and operand/result bus for the sequential slice adder.
// Optional subtract control (op) is present only when ADD_SEQ_SUB_EN is defined.
interface add_seq_if #(
    parameter int unsigned WORDS = 4
);
    logic               start;
`ifdef ADD_SEQ_SUB_EN
    logic               op;
`endif
    logic [6*WORDS-1:0] A;
    logic [6*WORDS-1:0] B;
    logic               cin;
    logic [6*WORDS-1:0] S;
    logic               cout;
    logic               busy;
    logic               done;

`ifdef ADD_SEQ_SUB_EN
    modport master (output start, op, A, B, cin, input S, cout, busy, done);
    modport slave  (input start, op, A, B, cin, output S, cout, busy, done);
`else
    modport master (output start, A, B, cin, input S, cout, busy, done);
    modport slave  (input start, A, B, cin, output S, cout, busy, done);
`endif
endinterface

// File: rtl/add_seq_ctrl.sv
// Sequential multi-word adder: one 6-bit adder slice reused WORDS times, LSB slice first.
// Optional feature macro: ADD_SEQ_SUB_EN adds the op input (1 = subtract A - B).
// Also holds the sum6bit slice adder used by the controller.

module sum6bit (
    input  logic [5:0] a,
    input  logic [5:0] b,
    input  logic       cin,
    output logic [5:0] sum,
    output logic       cout
);
    logic [6:0] total;

    // Full 6-bit add; bit 6 is the carry out.
    always_comb begin
        total = {1'b0, a} + {1'b0, b} + {6'd0, cin};
        sum   = total[5:0];
        cout  = total[6];
    end
endmodule

module add_seq_ctrl #(
    parameter int unsigned WORDS = 4
) (
    input  logic     clk,
    input  logic     rst,
    add_seq_if.slave bus
);
    localparam int unsigned W       = 6 * WORDS;
    localparam logic [2:0]  LAST_IDX = 3'(WORDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, b_q, s_q;
    logic           carry_q, cout_q;
    logic [2:0]     idx_q;

    logic           accept;
    logic           last;
    logic [W-1:0]   b_in;
    logic           cin_in;
    int unsigned    base;
    logic [5:0]     a_slice, b_slice, sum_slice;
    logic           slice_cout;

    // Start is honoured only outside RUN; last marks the final slice edge.
    always_comb begin
        accept = bus.start && (state_q == StIdle || state_q == StDone);
        last   = (state_q == StRun) && (idx_q == LAST_IDX);
    end

`ifdef ADD_SEQ_SUB_EN
    // Subtract as A + ~B + 1; cin is ignored when op is set.
    always_comb begin
        b_in   = bus.op ? ~bus.B : bus.B;
        cin_in = bus.op ? 1'b1 : bus.cin;
    end
`else
    // Plain add: operands pass straight through.
    always_comb begin
        b_in   = bus.B;
        cin_in = bus.cin;
    end
`endif

    // Select the current operand slices for the shared adder.
    always_comb begin
        base    = 6 * 32'(idx_q);
        a_slice = a_q[base +: 6];
        b_slice = b_q[base +: 6];
    end

    sum6bit u_sum6bit (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (sum_slice),
        .cout (slice_cout)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM next state: DONE always lasts one cycle, back-to-back start allowed from DONE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRun;
            StRun:   if (last) state_d = StDone;
            StDone:  state_d = bus.start ? StRun : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath: latch operands on accept, then write one result slice per RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            idx_q   <= 3'd0;
        end else if (accept) begin
            a_q     <= bus.A;
            b_q     <= b_in;
            carry_q <= cin_in;
            idx_q   <= 3'd0;
        end else if (state_q == StRun) begin
            s_q[base +: 6] <= sum_slice;
            carry_q        <= slice_cout;
            if (last) begin
                cout_q <= slice_cout;
                idx_q  <= 3'd0;
            end else begin
                idx_q  <= idx_q + 3'd1;
            end
        end
    end

    // Registered outputs; busy and done decode directly from the state register.
    always_comb begin
        bus.S    = s_q;
        bus.cout = cout_q;
        bus.busy = (state_q == StRun);
        bus.done = (state_q == StDone);
    end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed self-checking bench for add_seq_ctrl with WORDS = 4.
// Subtract scenarios run only when ADD_SEQ_SUB_EN is defined.
module tb_add_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    add_seq_if #(.WORDS(4)) bus ();

    add_seq_ctrl #(.WORDS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.cin = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        bus.op = 1'b0;
`endif
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
        checks++;
        if (bus.S !== 24'h000000) begin errors++; $display("FAIL reset_S got %h want 000000", bus.S); end
        checks++;
        if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", bus.cout); end
    endtask

    task automatic test_mid_reset();
        bus.A = 24'h0FFFFF;
        bus.B = 24'h000001;
        bus.cin = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL midrst_busy_run got %b want 1", bus.busy); end
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", bus.done); end
        checks++;
        if (bus.S !== 24'h000000) begin errors++; $display("FAIL midrst_S got %h want 000000", bus.S); end
        checks++;
        if (bus.cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got %b want 0", bus.cout); end
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL midrst_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    task automatic test_carry_chain();
        int n;
        bus.A = 24'hFFFFFF;
        bus.B = 24'h000001;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 10) begin
            if (bus.done === 1'b1) begin
                checks++; errors++; $display("FAIL carry_overlap got done=1 busy=1 want exclusive");
            end
            n++;
            tick();
        end
        checks++;
        if (n != 4) begin errors++; $display("FAIL carry_busy_cycles got %0d want 4", n); end
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL carry_done got %b want 1", bus.done); end
        checks++;
        if (bus.S !== 24'h000000) begin errors++; $display("FAIL carry_S got %h want 000000", bus.S); end
        checks++;
        if (bus.cout !== 1'b1) begin errors++; $display("FAIL carry_cout got %b want 1", bus.cout); end
        tick();
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL carry_done_pulse got %b want 0", bus.done); end
        checks++;
        if (bus.S !== 24'h000000 || bus.cout !== 1'b1) begin
            errors++; $display("FAIL carry_hold got S=%h cout=%b want 000000 1", bus.S, bus.cout);
        end
    endtask

    task automatic test_start_in_run();
        bus.A = 24'h012345;
        bus.B = 24'h054321;
        bus.cin = 1'b1;
        bus.start = 1'b1;
        tick();
        // Operands change and start stays high during RUN; both must be ignored.
        bus.A = 24'hABCDEF;
        bus.B = 24'h777777;
        bus.cin = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL run_busy got %b want 1", bus.busy); end
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL run_done got %b want 1", bus.done); end
        checks++;
        if (bus.S !== 24'h066667) begin errors++; $display("FAIL run_S got %h want 066667", bus.S); end
        checks++;
        if (bus.cout !== 1'b0) begin errors++; $display("FAIL run_cout got %b want 0", bus.cout); end
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc;
        int t1;
        int t2;
        bus.A = 24'h000010;
        bus.B = 24'h000020;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.A = 24'h000001;
        bus.B = 24'h000002;
        cyc = 0;
        while (bus.done !== 1'b1 && cyc < 20) begin tick(); cyc++; end
        t1 = cyc;
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL b2b_done1 got %b want 1", bus.done); end
        checks++;
        if (bus.S !== 24'h000030) begin errors++; $display("FAIL b2b_S1 got %h want 000030", bus.S); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_busy1 got %b want 0", bus.busy); end
        tick();
        cyc++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && cyc < 40) begin tick(); cyc++; end
        t2 = cyc;
        checks++;
        if (t2 - t1 != 5) begin errors++; $display("FAIL b2b_spacing got %0d want 5", t2 - t1); end
        checks++;
        if (bus.S !== 24'h000003) begin errors++; $display("FAIL b2b_S2 got %h want 000003", bus.S); end
        checks++;
        if (bus.cout !== 1'b0) begin errors++; $display("FAIL b2b_cout2 got %b want 0", bus.cout); end
        tick();
    endtask

    task automatic test_rst_start();
        bus.A = 24'h000001;
        bus.B = 24'h000001;
        bus.start = 1'b1;
        rst = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL rststart_busy got %b want 0", bus.busy); end
        rst = 1'b0;
        bus.start = 1'b0;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++; $display("FAIL rststart_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
        checks++;
        if (bus.S !== 24'h000000) begin errors++; $display("FAIL rststart_S got %h want 000000", bus.S); end
    endtask

`ifdef ADD_SEQ_SUB_EN
    task automatic test_subtract();
        bus.op = 1'b1;
        bus.cin = 1'b0;
        bus.A = 24'h000005;
        bus.B = 24'h000007;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL sub1_done got %b want 1", bus.done); end
        checks++;
        if (bus.S !== 24'hFFFFFE || bus.cout !== 1'b0) begin
            errors++; $display("FAIL sub1 got S=%h cout=%b want FFFFFE 0", bus.S, bus.cout);
        end
        tick();
        bus.A = 24'h000007;
        bus.B = 24'h000005;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (bus.S !== 24'h000002 || bus.cout !== 1'b1) begin
            errors++; $display("FAIL sub2 got S=%h cout=%b want 000002 1", bus.S, bus.cout);
        end
        bus.op = 1'b0;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_mid_reset();
        test_carry_chain();
        test_start_in_run();
        test_back_to_back();
        test_rst_start();
`ifdef ADD_SEQ_SUB_EN
        test_subtract();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
